serial_subtractor: RTL

//  Bit-serial unsigned/two's-complement subtractor: DIFF = A - B, one bit per clock, LSB first.

---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/full_subtractor_component.sv | 14 +
 rtl/serial_subtractor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the default operand width.
package serial_arith_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/full_subtractor_component.sv
// One-bit full subtractor: d = a - b - borrow_in, with borrow out.
// This is the subtracting counterpart of the ripple adder's per-bit cell.
module full_subtractor_component (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic d,
   output logic borrow_out
);

   assign d          = a ^ b ^ borrow_in;
   assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// It uses valid/ready handshakes on the operand side and on the result side.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               bf_q, bf_d;
   logic               borrow_q, borrow_d;
   logic               overflow_q, overflow_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;

   logic               cell_d;
   logic               cell_borrow;

   full_subtractor_component u_cell (
      .a          (a_q[0]),
      .b          (b_q[0]),
      .borrow_in  (bf_q),
      .d          (cell_d),
      .borrow_out (cell_borrow)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         diff_q     <= '0;
         cnt_q      <= '0;
         bf_q       <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         a_msb_q    <= 1'b0;
         b_msb_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         diff_q     <= diff_d;
         cnt_q      <= cnt_d;
         bf_q       <= bf_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
         a_msb_q    <= a_msb_d;
         b_msb_q    <= b_msb_d;
      end
   end

   // NOTE: every signal gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      diff_d     = diff_q;
      cnt_d      = cnt_q;
      bf_d       = bf_q;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;
      a_msb_d    = a_msb_q;
      b_msb_d    = b_msb_q;
      if (state_q == IDLE && in_valid) begin
         a_d     = a;
         b_d     = b;
         a_msb_d = a[WIDTH-1];
         b_msb_d = b[WIDTH-1];
         bf_d    = 1'b0;
         cnt_d   = '0;
      end else if (state_q == SHIFT) begin
         // Shift-then-set keeps this valid for WIDTH=1, where there is no upper slice.
         a_d               = a_q >> 1;
         b_d               = b_q >> 1;
         diff_d            = diff_q >> 1;
         diff_d[WIDTH-1]   = cell_d;
         bf_d              = cell_borrow;
         cnt_d             = cnt_q + CNT_W'(1);
         if (cnt_q == LAST_CNT) begin
            borrow_d   = cell_borrow;
            overflow_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   assign diff     = diff_q;
   assign borrow   = borrow_q;
   assign overflow = overflow_q;

endmodule
